dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the pipeline's memory-stage load/store requests. It accepts one request at a time, holds the pipeline with a stall signal while the access is in flight, and performs byte, half or word accesses with RISC-V load sign/zero extension. On completion it returns read data and a one-cycle acknowledge. It replaces the single-cycle data memory wherever a realistic, latency-bearing memory model is needed.

## Interface
- DATA_WIDTH, 32, data bus width; only 32 is supported
- ADDRESS_WIDTH, 32, byte-address width
- DEPTH_WORDS, 1024, storage depth in 32-bit words; power of two
- LATENCY, 2, cycles from request acceptance to acknowledge; must be 1 or greater

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-low
- MemRead  in  1  load request from the memory stage
- we  in  1  store request from the memory stage
- LS_mode  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- a  in  ADDRESS_WIDTH  byte address
- wd  in  DATA_WIDTH  store data, right-aligned
- rd  out  DATA_WIDTH  load result, registered, held until the next completion
- ack  out  1  one-cycle completion pulse
- stall  out  1  combinational hold request to the hazard logic
- misalign  out  1  one-cycle pulse with ack when the access was misaligned

## Operation
- The request is req = MemRead | we. If both are high, the request is a store.
- The state machine has three states: IDLE, WAIT and DONE.
- IDLE with req: latch a, wd, LS_mode and direction, then load the counter with LATENCY-1.
  - If LATENCY = 1, go to DONE.
  - Otherwise, go to WAIT.
- WAIT: decrement the counter. When the counter reads 1, go to DONE on the next edge and perform the access on that same edge.
- DONE: ack = 1 for exactly one cycle, then return to IDLE.
  - req is ignored in DONE because the memory stage still presents the completed request in that cycle.
- stall = (IDLE & req) | WAIT. stall is low in DONE.
- Word index = a[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Stores write byte lanes only:
  - SB writes lane a[1:0].
  - SH writes lanes a[1]*2 and a[1]*2+1.
  - SW writes all four lanes.
- Loads select the addressed byte or half, then sign-extend (000/001) or zero-extend (100/101). LW returns the whole word.
- Misalignment is any of:
  - a half access with a[0] = 1;
  - a word access with a[1:0] != 0;
  - an undefined LS_mode (011, 110, 111).
- A misaligned access still completes on the normal schedule. Memory is not written, rd is loaded with 0, and misalign pulses together with ack.
- Reset values: state IDLE, counter 0, rd 0, ack 0, misalign 0. Storage contents are not reset.
- Reset asserted mid-operation abandons the request with no write, and stall drops immediately.

## Timing
- Request first visible in cycle 0 while in IDLE. ack and rd are valid in cycle LATENCY.
- stall is high in cycles 0 through LATENCY-1, so it is high for exactly LATENCY cycles per access.
- Back-to-back requests are accepted no earlier than cycle LATENCY+1, giving a throughput of one access per LATENCY+1 cycles.
- The storage write commits on the edge ending cycle LATENCY-1. A load issued after the store's ack returns the new data.
- rd changes only on the edge entering DONE.

## Test plan
- Reset: drive rst low mid-WAIT → stall = 0, ack = 0 and rd = 0 immediately. After rst releases, a following LW of the same address shows the old contents, proving no write occurred.
- Word round trip at LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10 → stall is high for 2 cycles on each access, ack pulses in cycle 2, and rd = 0xDEADBEEF.
- Byte and half lanes: SW 0x00000000 to 0x20, SB 0x80 to 0x23, SH 0x8001 to 0x20, then:
  - LW 0x20 → rd = 0x80008001
  - LB 0x23 → rd = 0xFFFFFF80
  - LBU 0x23 → rd = 0x00000080
  - LH 0x20 → rd = 0xFFFF8001
- Misalignment: LW at 0x22 → ack and misalign pulse together and rd = 0. SH at 0x21 followed by LW 0x20 → the word is unchanged.
- Back-to-back and wrap-around at LATENCY=1, DEPTH_WORDS=1024:
  - SW 0x12345678 to 0x1000 → the value aliases to word 0, so LW 0x0 returns 0x12345678.
  - Requests held continuously → ack every second cycle, and no duplicate acceptance in DONE.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data memory with byte/half/word access, load
//            sign/zero extension, pipeline stall and one-cycle acknowledge.
// Revision : 1.0  initial release
// ============================================================================

module dmem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MemRead,
  input  logic                     we,
  input  logic [2:0]               LS_mode,
  input  logic [ADDRESS_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0]    wd,
  output logic [DATA_WIDTH-1:0]    rd,
  output logic                     ack,
  output logic                     stall,
  output logic                     misalign
);

  localparam int c_idxW = $clog2(DEPTH_WORDS);
  localparam int c_cntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_cntW-1:0] c_cntLoad = c_cntW'(LATENCY - 1);
  localparam logic [c_cntW-1:0] c_cntOne  = c_cntW'(1);
  localparam bit c_singleCycle = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_stateNext;
  logic [c_cntW-1:0]   r_cnt, w_cntNext;
  logic [c_idxW+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_mode;
  logic                r_write;
  logic [31:0]         r_rd;
  logic                r_ack;
  logic                r_misalign;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_req;
  logic                w_accept;
  logic                w_doAccess;
  logic [c_idxW+1:0]   w_accAddr;
  logic [c_idxW-1:0]   w_accIdx;
  logic [31:0]         w_accWd;
  logic [2:0]          w_accMode;
  logic                w_accWrite;
  logic                w_misalign;
  logic [3:0]          w_be;
  logic [31:0]         w_wrData;
  logic [31:0]         w_rdWord;
  logic [31:0]         w_rdShifted;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_loadData;
  logic                w_unusedAddr;

  // Gating with reset lets stall drop the instant reset asserts.
  assign w_req        = rst & (MemRead | we);
  assign w_unusedAddr = ^a[ADDRESS_WIDTH-1:c_idxW+2];

  // With single-cycle latency the access happens in IDLE on live inputs.
  assign w_accAddr  = (r_state == S_IDLE) ? a[c_idxW+1:0] : r_addr;
  assign w_accWd    = (r_state == S_IDLE) ? wd            : r_wdata;
  assign w_accMode  = (r_state == S_IDLE) ? LS_mode       : r_mode;
  assign w_accWrite = (r_state == S_IDLE) ? we            : r_write;
  assign w_accIdx   = w_accAddr[c_idxW+1:2];

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_accept    = 1'b0;
    w_doAccess  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept  = 1'b1;
          w_cntNext = c_cntLoad;
          if (c_singleCycle) begin
            w_stateNext = S_DONE;
            w_doAccess  = 1'b1;
          end else begin
            w_stateNext = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cntNext = r_cnt - c_cntOne;
        if (r_cnt == c_cntOne) begin
          w_stateNext = S_DONE;
          w_doAccess  = 1'b1;
        end
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    w_misalign = 1'b1;
    case (w_accMode)
      3'b000, 3'b100: w_misalign = 1'b0;
      3'b001, 3'b101: w_misalign = w_accAddr[0];
      3'b010:         w_misalign = |w_accAddr[1:0];
      default:        w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_be     = 4'b1111;
    w_wrData = w_accWd;
    case (w_accMode[1:0])
      2'b00: begin
        w_be     = 4'b0001 << w_accAddr[1:0];
        w_wrData = {4{w_accWd[7:0]}};
      end
      2'b01: begin
        w_be     = w_accAddr[1] ? 4'b1100 : 4'b0011;
        w_wrData = {2{w_accWd[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wrData = w_accWd;
      end
    endcase
  end

  assign w_rdWord    = r_mem[w_accIdx];
  assign w_rdShifted = w_rdWord >> {w_accAddr[1:0], 3'b000};
  assign w_byte      = w_rdShifted[7:0];
  assign w_half      = w_accAddr[1] ? w_rdWord[31:16] : w_rdWord[15:0];

  always_comb begin
    w_loadData = 32'h0;
    case (w_accMode)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b010:  w_loadData = w_rdWord;
      3'b100:  w_loadData = {24'h0, w_byte};
      3'b101:  w_loadData = {16'h0, w_half};
      default: w_loadData = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mode     <= '0;
      r_write    <= 1'b0;
      r_rd       <= '0;
      r_ack      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_ack      <= w_doAccess;
      r_misalign <= w_doAccess & w_misalign;
      if (w_accept) begin
        r_addr  <= a[c_idxW+1:0];
        r_wdata <= wd;
        r_mode  <= LS_mode;
        r_write <= we;
      end
      if (w_doAccess) begin
        if (w_misalign) begin
          r_rd <= '0;
        end else if (!w_accWrite) begin
          r_rd <= w_loadData;
        end
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_doAccess && w_accWrite && !w_misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_accIdx][8*i +: 8] <= w_wrData[8*i +: 8];
        end
      end
    end
  end

  assign rd       = r_rd;
  assign ack      = r_ack;
  assign misalign = r_misalign;
  assign stall    = ((r_state == S_IDLE) & w_req) | (r_state == S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder at LATENCY 2 and 1.
// Revision : 1.0  initial release
// ============================================================================

module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  typedef struct {
    int          d;
    logic        memRead;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] expRd;
    logic        expMis;
    logic        chkRd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        chk;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mr   [2];
  logic        wen  [2];
  logic [2:0]  mode [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];

  logic [31:0] rd0, rd1;
  logic        ack0, ack1, stall0, stall1, mis0, mis1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];
  vec_t tbl [20];

  dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(mr[0]), .we(wen[0]), .LS_mode(mode[0]),
    .a(addr[0]), .wd(wdat[0]), .rd(rd0), .ack(ack0), .stall(stall0), .misalign(mis0)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .MemRead(mr[1]), .we(wen[1]), .LS_mode(mode[1]),
    .a(addr[1]), .wd(wdat[1]), .rd(rd1), .ack(ack1), .stall(stall1), .misalign(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input logic memRead, input logic we, input logic [2:0] md,
                              input logic [31:0] ad, input logic [31:0] w, input logic [31:0] er,
                              input logic em, input logic cr);
    vec_t v;
    v.d = d; v.memRead = memRead; v.we = we; v.mode = md; v.addr = ad; v.wd = w;
    v.expRd = er; v.expMis = em; v.chkRd = cr;
    return v;
  endfunction

  task automatic idleInputs(input int d);
    mr[d] = 1'b0; wen[d] = 1'b0; mode[d] = 3'b000; addr[d] = '0; wdat[d] = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic access(input vec_t v);
    exp_t e;
    int   cyc;
    int   lat;
    bit   got;
    logic [31:0] vRd;
    logic vAck, vStall, vMis;
    lat = (v.d == 0) ? LAT0 : LAT1;
    e.rd = v.expRd; e.mis = v.expMis; e.chk = v.chkRd;
    sb.push_back(e);
    mr[v.d] = v.memRead; wen[v.d] = v.we; mode[v.d] = v.mode;
    addr[v.d] = v.addr; wdat[v.d] = v.wd;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      vRd    = (v.d == 0) ? rd0    : rd1;
      vAck   = (v.d == 0) ? ack0   : ack1;
      vStall = (v.d == 0) ? stall0 : stall1;
      vMis   = (v.d == 0) ? mis0   : mis1;
      if (vAck) begin
        got = 1'b1;
        chk("ackCycle", cyc, lat);
        chk("stallInDone", {31'h0, vStall}, 32'h0);
        e = sb.pop_front();
        if (e.chk) chk("rd", vRd, e.rd);
        chk("misalign", {31'h0, vMis}, {31'h0, e.mis});
      end else begin
        chk("stallWhileBusy", {31'h0, vStall}, 32'h1);
      end
      cyc++;
    end
    if (!got) begin
      chk("ackTimeout", 32'h0, 32'h1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    idleInputs(v.d);
  endtask

  initial begin
    int nAck;
    exp_t e;
    logic expAck;

    // Vectors: {dut, MemRead, we, mode, addr, wd, expected rd, expected misalign, check rd}
    tbl[0]  = mk(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0);
    tbl[1]  = mk(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
    tbl[2]  = mk(0, 0, 1, 3'b010, 32'h20, 32'h00000000, 32'h0,        0, 0);
    tbl[3]  = mk(0, 0, 1, 3'b000, 32'h23, 32'h00000080, 32'h0,        0, 0);
    tbl[4]  = mk(0, 0, 1, 3'b001, 32'h20, 32'h00008001, 32'h0,        0, 0);
    tbl[5]  = mk(0, 1, 0, 3'b010, 32'h20, 32'h0,        32'h80008001, 0, 1);
    tbl[6]  = mk(0, 1, 0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 0, 1);
    tbl[7]  = mk(0, 1, 0, 3'b100, 32'h23, 32'h0,        32'h00000080, 0, 1);
    tbl[8]  = mk(0, 1, 0, 3'b001, 32'h20, 32'h0,        32'hFFFF8001, 0, 1);
    tbl[9]  = mk(0, 1, 0, 3'b000, 32'h20, 32'h0,        32'h00000001, 0, 1);
    tbl[10] = mk(0, 1, 0, 3'b001, 32'h22, 32'h0,        32'hFFFF8000, 0, 1);
    tbl[11] = mk(0, 1, 0, 3'b101, 32'h22, 32'h0,        32'h00008000, 0, 1);
    tbl[12] = mk(0, 1, 0, 3'b010, 32'h22, 32'h0,        32'h0,        1, 1);
    tbl[13] = mk(0, 0, 1, 3'b001, 32'h21, 32'h0000FFFF, 32'h0,        1, 1);
    tbl[14] = mk(0, 1, 0, 3'b010, 32'h20, 32'h0,        32'h80008001, 0, 1);
    tbl[15] = mk(0, 0, 1, 3'b110, 32'h20, 32'hFFFFFFFF, 32'h0,        1, 1);
    tbl[16] = mk(0, 1, 0, 3'b010, 32'h20, 32'h0,        32'h80008001, 0, 1);
    tbl[17] = mk(0, 1, 1, 3'b010, 32'h30, 32'h11223344, 32'h0,        0, 0);
    tbl[18] = mk(0, 1, 0, 3'b100, 32'h31, 32'h0,        32'h00000033, 0, 1);
    tbl[19] = mk(1, 0, 1, 3'b010, 32'h1000, 32'h12345678, 32'h0,      0, 0);

    rst = 1'b0;
    idleInputs(0);
    idleInputs(1);
    repeat (3) @(negedge clk);
    chk("resetRd0",    rd0,              32'h0);
    chk("resetAck0",   {31'h0, ack0},    32'h0);
    chk("resetStall0", {31'h0, stall0},  32'h0);
    chk("resetMis0",   {31'h0, mis0},    32'h0);
    chk("resetRd1",    rd1,              32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) access(tbl[i]);

    // Wrapped store on the single-cycle instance aliases word 0.
    access(mk(1, 1, 0, 3'b010, 32'h0, 32'h0, 32'h12345678, 0, 1));

    // Reset during WAIT must abandon the store.
    access(mk(0, 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0));
    access(mk(0, 1, 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1));
    wen[0] = 1'b1; mode[0] = 3'b010; addr[0] = 32'h40; wdat[0] = 32'h55555555;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rstMidStall", {31'h0, stall0}, 32'h0);
    chk("rstMidAck",   {31'h0, ack0},   32'h0);
    chk("rstMidRd",    rd0,             32'h0);
    idleInputs(0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(mk(0, 1, 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1));

    // Continuous request at single-cycle latency: accept, done, accept, ...
    mr[1] = 1'b1; mode[1] = 3'b010; addr[1] = 32'h0;
    nAck = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expAck = (i % 2 == 1);
      chk("b2bAck",   {31'h0, ack1},   {31'h0, expAck});
      chk("b2bStall", {31'h0, stall1}, {31'h0, ~expAck});
      if (stall1) begin
        e.rd = 32'h12345678; e.mis = 1'b0; e.chk = 1'b1;
        sb.push_back(e);
      end
      if (ack1) begin
        nAck++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2bRd", rd1, e.rd);
        end else begin
          chk("b2bUnexpectedAck", 32'h1, 32'h0);
        end
      end
    end
    @(posedge clk);
    #1;
    idleInputs(1);
    chk("b2bAckCount", nAck, 4);
    chk("scoreboardEmpty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
